// File: rtl/mem_arbiter_pkg.sv
// Shared bus encodings, tag sizing and owner encoding for the memory-port arbiter.
// The popcount helper is shared by the tag table.
package mem_arbiter_pkg;

  localparam int MEM_TAG_BITS = 4;
  localparam int NUM_TAGS     = 1 << MEM_TAG_BITS;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } owner_e;

  typedef logic [MEM_TAG_BITS-1:0] mem_tag_t;
  typedef logic [MEM_TAG_BITS:0]   tag_count_t;

  function automatic tag_count_t popcount(input logic [NUM_TAGS-1:0] v);
    tag_count_t n;
    n = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      n = n + tag_count_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for memory transaction tags 1..15.
// A returning tag is retired before a same-cycle allocation, so an immediate reuse is not a collision.
module mem_tag_table
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en,
  input  mem_tag_t   alloc_tag,
  input  owner_e     alloc_owner,
  input  mem_tag_t   lookup_tag,
  output logic       hit,
  output owner_e     hit_owner,
  output tag_count_t count,
  output logic       collision
);

  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;
  logic                collision_d;

  assign hit       = (lookup_tag != '0) && valid_q[lookup_tag];
  assign hit_owner = owner_e'(owner_q[lookup_tag]);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d     = valid_q;
    owner_d     = owner_q;
    collision_d = 1'b0;
    if (hit) begin
      valid_d[lookup_tag] = 1'b0;
    end
    if (alloc_en && (alloc_tag != '0)) begin
      collision_d         = valid_d[alloc_tag];
      valid_d[alloc_tag]  = 1'b1;
      owner_d[alloc_tag]  = alloc_owner;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      count     <= '0;
      collision <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      count     <= popcount(valid_d);
      collision <= collision_d;
    end
  end

  // NOTE: owner bits are storage qualified by valid_q, so they are deliberately left out of reset.
  always_ff @(posedge clock) begin
    owner_q <= owner_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between icache and dcache, with dcache priority
// bounded by an icache starvation limit, and steers returning load data to the tag owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  icache2arb_command,
  input  logic [63:0] icache2arb_addr,
  input  logic [1:0]  dcache2arb_command,
  input  logic [63:0] dcache2arb_addr,
  input  logic [63:0] dcache2arb_data,
  input  logic [3:0]  mem2arb_response,
  input  logic [63:0] mem2arb_data,
  input  logic [3:0]  mem2arb_tag,
  output logic [1:0]  arb2mem_command,
  output logic [63:0] arb2mem_addr,
  output logic [63:0] arb2mem_data,
  output logic [3:0]  arb2icache_response,
  output logic [63:0] arb2icache_data,
  output logic [3:0]  arb2icache_tag,
  output logic [3:0]  arb2dcache_response,
  output logic [63:0] arb2dcache_data,
  output logic [3:0]  arb2dcache_tag,
  output logic [4:0]  outstanding_count,
  output logic        tag_collision
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic       icache_req, dcache_req;
  logic       grant_icache, grant_dcache;
  logic       alloc_en;
  logic [3:0] starve_cnt, starve_d;
  logic       ret_hit;
  owner_e     ret_owner;

  assign icache_req   = (icache2arb_command != BUS_NONE);
  assign dcache_req   = (dcache2arb_command != BUS_NONE);
  assign grant_icache = icache_req && (!dcache_req || (starve_cnt == STARVE_MAX));
  assign grant_dcache = dcache_req && !grant_icache;

  // Icache only ever reads, so any icache command is forwarded as a load.
  always_comb begin
    arb2mem_command     = BUS_NONE;
    arb2mem_addr        = '0;
    arb2mem_data        = '0;
    arb2icache_response = '0;
    arb2dcache_response = '0;
    if (grant_icache) begin
      arb2mem_command     = BUS_LOAD;
      arb2mem_addr        = icache2arb_addr;
      arb2icache_response = mem2arb_response;
    end else if (grant_dcache) begin
      arb2mem_command     = dcache2arb_command;
      arb2mem_addr        = dcache2arb_addr;
      arb2mem_data        = dcache2arb_data;
      arb2dcache_response = mem2arb_response;
    end
  end

  assign alloc_en = (grant_icache || (grant_dcache && (dcache2arb_command == BUS_LOAD)))
                    && (mem2arb_response != '0);

  mem_tag_table u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2arb_response),
    .alloc_owner (grant_dcache ? OWNER_DCACHE : OWNER_ICACHE),
    .lookup_tag  (mem2arb_tag),
    .hit         (ret_hit),
    .hit_owner   (ret_owner),
    .count       (outstanding_count),
    .collision   (tag_collision)
  );

  assign arb2icache_data = mem2arb_data;
  assign arb2dcache_data = mem2arb_data;
  assign arb2icache_tag  = (ret_hit && (ret_owner == OWNER_ICACHE)) ? mem2arb_tag : '0;
  assign arb2dcache_tag  = (ret_hit && (ret_owner == OWNER_DCACHE)) ? mem2arb_tag : '0;

  // Starvation counts cycles icache waits without an accepted request; saturates at the limit.
  always_comb begin
    starve_d = starve_cnt;
    if (!icache_req || (grant_icache && (mem2arb_response != '0))) begin
      starve_d = '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_d = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table plus randomized traffic
// compared against a behavioural owner-table model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam logic [63:0] DC_DATA = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] M_DATA  = 64'h0000_0000_0000_DEAD;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache2arb_command, dcache2arb_command;
  logic [63:0] icache2arb_addr, dcache2arb_addr, dcache2arb_data;
  logic [3:0]  mem2arb_response, mem2arb_tag;
  logic [63:0] mem2arb_data;
  logic [1:0]  arb2mem_command;
  logic [63:0] arb2mem_addr, arb2mem_data;
  logic [3:0]  arb2icache_response, arb2icache_tag, arb2dcache_response, arb2dcache_tag;
  logic [63:0] arb2icache_data, arb2dcache_data;
  logic [4:0]  outstanding_count;
  logic        tag_collision;

  always #5 clock = ~clock;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock               (clock),
    .reset               (reset),
    .icache2arb_command  (icache2arb_command),
    .icache2arb_addr     (icache2arb_addr),
    .dcache2arb_command  (dcache2arb_command),
    .dcache2arb_addr     (dcache2arb_addr),
    .dcache2arb_data     (dcache2arb_data),
    .mem2arb_response    (mem2arb_response),
    .mem2arb_data        (mem2arb_data),
    .mem2arb_tag         (mem2arb_tag),
    .arb2mem_command     (arb2mem_command),
    .arb2mem_addr        (arb2mem_addr),
    .arb2mem_data        (arb2mem_data),
    .arb2icache_response (arb2icache_response),
    .arb2icache_data     (arb2icache_data),
    .arb2icache_tag      (arb2icache_tag),
    .arb2dcache_response (arb2dcache_response),
    .arb2dcache_data     (arb2dcache_data),
    .arb2dcache_tag      (arb2dcache_tag),
    .outstanding_count   (outstanding_count),
    .tag_collision       (tag_collision)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns each tag, how long icache has waited.
  bit m_valid [16];
  bit m_owner [16];   // 1 = dcache
  int m_starve;
  int m_count;
  bit m_coll;

  typedef struct {
    logic [1:0]  ic_cmd;
    logic [63:0] ic_addr;
    logic [1:0]  dc_cmd;
    logic [63:0] dc_addr;
    logic [3:0]  resp;
    logic [3:0]  mtag;
    logic        rst;
    logic [63:0] e_addr;
    logic [3:0]  e_ic_resp, e_dc_resp, e_ic_tag, e_dc_tag;
    logic [4:0]  e_count;
    logic        e_coll;
  } vec_t;

  function automatic vec_t mk(int ic, int ia, int dc, int da, int rsp, int tg, int rs,
                              int ea, int eir, int edr, int eit, int edt, int ec, int ecl);
    vec_t r;
    r.ic_cmd = 2'(ic);  r.ic_addr = 64'(ia);
    r.dc_cmd = 2'(dc);  r.dc_addr = 64'(da);
    r.resp = 4'(rsp);   r.mtag = 4'(tg);  r.rst = 1'(rs);
    r.e_addr = 64'(ea);
    r.e_ic_resp = 4'(eir); r.e_dc_resp = 4'(edr);
    r.e_ic_tag = 4'(eit);  r.e_dc_tag = 4'(edt);
    r.e_count = 5'(ec);    r.e_coll = 1'(ecl);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ic, input logic [63:0] ia, input logic [1:0] dc,
                       input logic [63:0] da, input logic [63:0] dd, input logic [3:0] rsp,
                       input logic [3:0] tg, input logic [63:0] md, input logic rs);
    icache2arb_command = ic;  icache2arb_addr = ia;
    dcache2arb_command = dc;  dcache2arb_addr = da;  dcache2arb_data = dd;
    mem2arb_response = rsp;   mem2arb_tag = tg;       mem2arb_data = md;
    reset = rs;
  endtask

  // 0 = nobody, 1 = icache, 2 = dcache
  function automatic int winner();
    bit ic_req, dc_req;
    ic_req = (icache2arb_command != 2'd0);
    dc_req = (dcache2arb_command != 2'd0);
    if (ic_req && (!dc_req || m_starve == LIMIT)) return 1;
    if (dc_req) return 2;
    return 0;
  endfunction

  task automatic model_check();
    int w;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_data;
    logic [3:0]  e_ir, e_dr, e_it, e_dt;
    bit hit;
    w = winner();
    e_cmd = 2'd0; e_addr = '0; e_data = '0; e_ir = '0; e_dr = '0;
    if (w == 1) begin
      e_cmd = 2'd1; e_addr = icache2arb_addr; e_ir = mem2arb_response;
    end else if (w == 2) begin
      e_cmd = dcache2arb_command; e_addr = dcache2arb_addr; e_data = dcache2arb_data;
      e_dr = mem2arb_response;
    end
    hit  = (mem2arb_tag != 4'd0) && m_valid[mem2arb_tag];
    e_it = (hit && !m_owner[mem2arb_tag]) ? mem2arb_tag : 4'd0;
    e_dt = (hit &&  m_owner[mem2arb_tag]) ? mem2arb_tag : 4'd0;
    check("mem_command", 64'(arb2mem_command), 64'(e_cmd));
    check("mem_addr", arb2mem_addr, e_addr);
    check("mem_data", arb2mem_data, e_data);
    check("icache_response", 64'(arb2icache_response), 64'(e_ir));
    check("dcache_response", 64'(arb2dcache_response), 64'(e_dr));
    check("icache_tag", 64'(arb2icache_tag), 64'(e_it));
    check("dcache_tag", 64'(arb2dcache_tag), 64'(e_dt));
    check("icache_data", arb2icache_data, mem2arb_data);
    check("dcache_data", arb2dcache_data, mem2arb_data);
    check("outstanding_count", 64'(outstanding_count), 64'(m_count));
    check("tag_collision", 64'(tag_collision), 64'(m_coll));
  endtask

  // Applies the rules for one clock edge using the inputs that were held over it.
  task automatic model_step();
    int  w;
    bit  alloc;
    int  rsp;
    if (reset) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_starve = 0; m_count = 0; m_coll = 1'b0;
      return;
    end
    w   = winner();
    rsp = int'(mem2arb_response);
    if (mem2arb_tag != 4'd0 && m_valid[mem2arb_tag]) m_valid[mem2arb_tag] = 1'b0;
    alloc = (w == 1 || (w == 2 && dcache2arb_command == 2'd1)) && rsp != 0;
    m_coll = alloc && m_valid[rsp];
    if (alloc) begin
      m_valid[rsp] = 1'b1;
      m_owner[rsp] = (w == 2);
    end
    m_count = 0;
    foreach (m_valid[i]) m_count += int'(m_valid[i]);
    if (icache2arb_command == 2'd0 || (w == 1 && rsp != 0)) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
  endtask

  task automatic advance();
    @(posedge clock);
    model_step();
    #1;
  endtask

  vec_t vecs [33];

  initial begin
    foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_owner[i] = 1'b0; end
    m_starve = 0; m_count = 0; m_coll = 1'b0;

    // Icache alone, dcache store, interleaved tags, tag 7 reuse, reset, starvation.
    vecs[0]  = mk(1,'h100, 0,0,     3,0,0, 'h100, 3,0,0,0, 0,0);
    vecs[1]  = mk(0,0,     0,0,     0,0,0, 0,     0,0,0,0, 1,0);
    vecs[2]  = mk(0,0,     0,0,     0,3,0, 0,     0,0,3,0, 1,0);
    vecs[3]  = mk(0,0,     0,0,     0,0,0, 0,     0,0,0,0, 0,0);
    vecs[4]  = mk(0,0,     2,'h200, 5,0,0, 'h200, 0,5,0,0, 0,0);
    vecs[5]  = mk(0,0,     0,0,     0,5,0, 0,     0,0,0,0, 0,0);
    vecs[6]  = mk(1,'h300, 0,0,     1,0,0, 'h300, 1,0,0,0, 0,0);
    vecs[7]  = mk(0,0,     1,'h400, 2,0,0, 'h400, 0,2,0,0, 1,0);
    vecs[8]  = mk(0,0,     0,0,     0,2,0, 0,     0,0,0,2, 2,0);
    vecs[9]  = mk(0,0,     0,0,     0,1,0, 0,     0,0,1,0, 1,0);
    vecs[10] = mk(0,0,     0,0,     0,0,0, 0,     0,0,0,0, 0,0);
    vecs[11] = mk(0,0,     1,'h500, 7,0,0, 'h500, 0,7,0,0, 0,0);
    vecs[12] = mk(1,'h600, 0,0,     7,7,0, 'h600, 7,0,0,7, 1,0);
    vecs[13] = mk(0,0,     0,0,     0,0,0, 0,     0,0,0,0, 1,0);
    vecs[14] = mk(0,0,     1,'h700, 7,0,0, 'h700, 0,7,0,0, 1,0);
    vecs[15] = mk(0,0,     0,0,     0,0,0, 0,     0,0,0,0, 1,1);
    vecs[16] = mk(0,0,     0,0,     0,7,0, 0,     0,0,0,7, 1,0);
    vecs[17] = mk(0,0,     0,0,     0,0,0, 0,     0,0,0,0, 0,0);
    vecs[18] = mk(1,'h800, 0,0,     1,0,0, 'h800, 1,0,0,0, 0,0);
    vecs[19] = mk(0,0,     1,'h900, 2,0,0, 'h900, 0,2,0,0, 1,0);
    vecs[20] = mk(0,0,     1,'hA00, 3,0,0, 'hA00, 0,3,0,0, 2,0);
    vecs[21] = mk(0,0,     0,0,     0,0,1, 0,     0,0,0,0, 3,0);
    vecs[22] = mk(0,0,     0,0,     0,1,0, 0,     0,0,0,0, 0,0);
    vecs[23] = mk(0,0,     0,0,     0,2,0, 0,     0,0,0,0, 0,0);
    vecs[24] = mk(0,0,     0,0,     0,3,0, 0,     0,0,0,0, 0,0);
    for (int i = 25; i < 29; i++)
      vecs[i] = mk(1,'hA0, 1,'hB0,  0,0,0, 'hB0,  0,0,0,0, 0,0);
    vecs[29] = mk(1,'hA0,  1,'hB0,  9,0,0, 'hA0,  9,0,0,0, 0,0);
    vecs[30] = mk(1,'hA0,  1,'hB0,  0,0,0, 'hB0,  0,0,0,0, 1,0);
    vecs[31] = mk(0,0,     0,0,     0,9,0, 0,     0,0,9,0, 1,0);
    vecs[32] = mk(0,0,     0,0,     0,0,0, 0,     0,0,0,0, 0,0);

    drive(2'd0, '0, 2'd0, '0, '0, 4'd0, 4'd0, '0, 1'b1);
    @(posedge clock);
    @(posedge clock);
    #1;
    // Reset state, still in reset: nothing requested, table empty.
    #3;
    model_check();
    advance();

    foreach (vecs[i]) begin
      drive(vecs[i].ic_cmd, vecs[i].ic_addr, vecs[i].dc_cmd, vecs[i].dc_addr, DC_DATA,
            vecs[i].resp, vecs[i].mtag, M_DATA, vecs[i].rst);
      #3;
      model_check();
      check($sformatf("vec%0d_mem_addr", i), arb2mem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_ic_resp", i), 64'(arb2icache_response), 64'(vecs[i].e_ic_resp));
      check($sformatf("vec%0d_dc_resp", i), 64'(arb2dcache_response), 64'(vecs[i].e_dc_resp));
      check($sformatf("vec%0d_ic_tag", i), 64'(arb2icache_tag), 64'(vecs[i].e_ic_tag));
      check($sformatf("vec%0d_dc_tag", i), 64'(arb2dcache_tag), 64'(vecs[i].e_dc_tag));
      check($sformatf("vec%0d_count", i), 64'(outstanding_count), 64'(vecs[i].e_count));
      check($sformatf("vec%0d_coll", i), 64'(tag_collision), 64'(vecs[i].e_coll));
      advance();
    end

    // Saturated starvation with icache rejected: icache keeps the grant until accepted.
    for (int i = 0; i < 6; i++) begin
      drive(2'd1, 64'hC0, 2'd2, 64'hD0, DC_DATA, 4'd0, 4'd0, M_DATA, 1'b0);
      #3;
      model_check();
      check($sformatf("starve_hold%0d_addr", i), arb2mem_addr, (i < LIMIT) ? 64'hD0 : 64'hC0);
      advance();
    end

    for (int n = 0; n < 600; n++) begin
      logic [3:0] rsp;
      rsp = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
      drive(2'($urandom_range(0, 2)), {$urandom, $urandom},
            2'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
            rsp, 4'($urandom_range(0, 15)), {$urandom, $urandom},
            ($urandom_range(0, 49) == 0));
      #3;
      model_check();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single processor–memory port between the instruction cache and the data cache. Each cycle it grants one requester and forwards that requester's command, address and store data to memory. It records which requester owns each 4-bit memory transaction tag, and steers returning load data only to that owner. Sits between `icache` / dcache controllers and the `Imem2proc_*` / `proc2Imem_*` memory interface.

## Interface
- `STARVE_LIMIT`, 4: consecutive unserviced icache cycles after which icache takes priority for one grant (1..15).
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `icache2arb_command` in 2: `BUS_NONE`/`BUS_LOAD` (`BUS_STORE` treated as `BUS_LOAD`).
- `icache2arb_addr` in 64: icache line address.
- `dcache2arb_command` in 2: `BUS_NONE`/`BUS_LOAD`/`BUS_STORE`.
- `dcache2arb_addr` in 64, `dcache2arb_data` in 64: dcache address and store data.
- `mem2arb_response` in 4: memory acceptance tag, 0 = rejected.
- `mem2arb_data` in 64, `mem2arb_tag` in 4: returning load data and its tag (0 = none).
- `arb2mem_command` out 2, `arb2mem_addr` out 64, `arb2mem_data` out 64: to memory.
- `arb2icache_response` out 4, `arb2icache_data` out 64, `arb2icache_tag` out 4: icache view of memory.
- `arb2dcache_response` out 4, `arb2dcache_data` out 64, `arb2dcache_tag` out 4: dcache view of memory.
- `outstanding_count` out 5: number of valid owner-table entries.
- `tag_collision` out 1: one-cycle pulse when an allocation hits an already-valid tag.

## Operation
- Grant is combinational.
  - Dcache wins when it requests, unless `starve_cnt == STARVE_LIMIT` and icache requests; then icache wins.
  - If only one requester is active, it wins. If neither is active, memory sees `BUS_NONE`, address 0 and data 0.
- Forwarding: the granted requester's command, address and data go to memory. For an icache grant, `arb2mem_data` is 0.
- Acceptance: `mem2arb_response` goes only to the granted requester's `*_response`. The other requester sees 0.
- Owner table: 15 entries (tags 1..15), each holding `valid` and `owner` (0 = icache, 1 = dcache).
  - On a granted `BUS_LOAD` with nonzero response: set `valid[resp] = 1` and `owner[resp] = grantee`.
  - Stores are never recorded.
- Data return: when `mem2arb_tag != 0` and `valid[tag]`, drive that tag and `mem2arb_data` to the owner and clear `valid[tag]`.
  - The non-owner's `*_tag` is 0.
  - A tag with `valid == 0` goes to neither requester and is dropped.
  - Both `*_data` outputs always carry `mem2arb_data`. Only `*_tag` qualifies it.
- Same tag returned and reallocated in one cycle: the retire happens first, then the allocation. The entry ends valid with the new owner, and `tag_collision` stays 0.
- Allocation onto a valid tag that is not retired in the same cycle: overwrite the owner and pulse `tag_collision`.
- `starve_cnt` (4 bits, saturating at `STARVE_LIMIT`):
  - Increments when icache requests and is not granted, or is granted but `mem2arb_response == 0`.
  - Clears when icache is granted with a nonzero response, or when icache is not requesting.
- `outstanding_count` = popcount of `valid`. It is registered and reflects the table after the last edge.

## Timing
- Zero-latency combinational path from requester commands and `mem2arb_*` to all outputs except `outstanding_count` and `tag_collision`.
- Owner table, `starve_cnt`, `outstanding_count` and `tag_collision` update on the `posedge clock` with `` `SD `` delay.
- `tag_collision` is registered and is visible the cycle after the allocation.
- A tag allocated in cycle N can return at the earliest in cycle N+1 and is routed correctly.
- Reset: all `valid` = 0, `starve_cnt` = 0, `outstanding_count` = 0, `tag_collision` = 0.
  - The combinational outputs follow their inputs. With no requests, all commands, responses and tags are 0.
  - Reset mid-transaction discards all outstanding ownership. Later returns of those tags are dropped.

## Structure
- `BUS_NONE`, `BUS_LOAD` and `BUS_STORE` come from the shared system defines header, as does `` `SD ``.
- Add `MEM_TAG_BITS = 4` and an owner encoding constant (`OWNER_ICACHE` = 0, `OWNER_DCACHE` = 1) to the shared header.
- Natural sub-module: `mem_tag_table`. It holds the 15-entry valid/owner storage with ports for allocate, retire and lookup, plus the popcount.
- Grant and starvation logic stay in `mem_arbiter`.

## Test plan
- Icache alone: LOAD addr 0x100, response 3, tag 3 returned two cycles later with data 0xDEAD → icache sees response 3, then tag 3 with data 0xDEAD. Dcache sees response 0 and tag 0.
- Both request with `STARVE_LIMIT` = 4: dcache is granted in cycles 0–3 (icache response 0) and icache in cycle 4. `starve_cnt` reads 1, 2, 3, 4, then 0 after the icache grant.
- Dcache STORE accepted with response 5, then memory returns tag 5 → dropped, neither sees tag 5, `outstanding_count` unchanged.
- Interleaving: icache gets tag 1 and dcache gets tag 2. Tags return as 2 then 1 → each goes only to its owner. `outstanding_count` goes 1, 2, 1, 0.
- Same-cycle retire and reallocate of tag 7 (old owner dcache, new owner icache) → dcache receives the data, entry becomes owner icache, `tag_collision` = 0. Reallocating a still-valid tag 7 pulses `tag_collision` the next cycle.
- Reset asserted with 3 tags outstanding → `outstanding_count` = 0 after the edge. Later returns of those tags reach no requester.
